dmem_arbiter: RTL and testbench

- Shares the single data-memory port (daddr/dwdata/we/drdata) and the 4-register memory-mapped peripheral port (ce_p/we_p/addr/wdata/rdata) between two requesters.
- Master 0 is the CPU load/store path; master 1 is a DMA/debug master.
- Round-robin arbitration with a bounded hold counter, address decode of the peripheral window, and a registered read-return path.
- Sits between the masters and the data memory plus peripheral.

---
 rtl/dmem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter : two-master round-robin arbiter for the data memory port and
//                the 4-register peripheral window, with registered read return.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter #(
  parameter logic [31:0] PERIPH_BASE = 32'd512,
  parameter int unsigned PERIPH_SPAN = 16,
  parameter int unsigned MAX_HOLD    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [3:0]  m0_we,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [3:0]  m1_we,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  we,
  input  logic [31:0] drdata,
  output logic        ce_p,
  output logic        we_p,
  output logic [1:0]  addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] c_HOLD_MAX = HW'(MAX_HOLD);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [HW-1:0] r_hold, w_hold_nxt, w_hold_inc;
  logic          r_prio, w_prio_nxt;
  logic          w_sel, w_own, w_own_req, w_oth_req, w_gnt;
  logic [31:0]   w_addr, w_wdata, w_rd_src;
  logic [3:0]    w_we;
  logic          w_periph;
  logic          r_m0_rvalid, r_m1_rvalid;
  logic [31:0]   r_m0_rdata, r_m1_rdata;

  assign w_sel     = (r_state == S_OWN1);
  assign w_own     = (r_state != S_IDLE);
  assign w_own_req = w_sel ? m1_req : m0_req;
  assign w_oth_req = w_sel ? m0_req : m1_req;
  assign w_gnt     = w_own && w_own_req;
  assign m0_gnt    = w_gnt && !w_sel;
  assign m1_gnt    = w_gnt && w_sel;

  assign w_addr  = w_sel ? m1_addr  : m0_addr;
  assign w_wdata = w_sel ? m1_wdata : m0_wdata;
  assign w_we    = w_sel ? m1_we    : m0_we;

  // 33-bit compare keeps the exclusive upper bound correct near the top of memory
  assign w_periph = ({1'b0, w_addr} >= {1'b0, PERIPH_BASE}) &&
                    ({1'b0, w_addr} <  ({1'b0, PERIPH_BASE} + 33'(PERIPH_SPAN)));
  assign w_rd_src = w_periph ? rdata : drdata;

  always_comb begin
    daddr  = '0;
    dwdata = '0;
    we     = '0;
    ce_p   = 1'b0;
    we_p   = 1'b0;
    addr   = '0;
    wdata  = '0;
    if (w_gnt) begin
      if (w_periph) begin
        ce_p  = 1'b1;
        we_p  = |w_we;
        addr  = w_addr[3:2];
        wdata = w_wdata;
      end else begin
        daddr  = w_addr;
        dwdata = w_wdata;
        we     = w_we;
      end
    end
  end

  assign w_hold_inc = (r_hold == c_HOLD_MAX) ? r_hold : r_hold + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_prio_nxt  = r_prio;
    case (r_state)
      S_IDLE: begin
        if (m0_req && m1_req) w_state_nxt = r_prio ? S_OWN1 : S_OWN0;
        else if (m0_req)      w_state_nxt = S_OWN0;
        else if (m1_req)      w_state_nxt = S_OWN1;
      end
      S_OWN0, S_OWN1: begin
        if (w_gnt) begin
          w_hold_nxt = w_hold_inc;
          w_prio_nxt = ~w_sel;
        end
        if (w_oth_req && (!w_own_req || w_hold_inc == c_HOLD_MAX)) begin
          w_state_nxt = w_sel ? S_OWN0 : S_OWN1;
          w_hold_nxt  = '0;
        end else if (!w_own_req && !w_oth_req) begin
          w_state_nxt = S_IDLE;
          w_hold_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_hold_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_hold  <= '0;
      r_prio  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_prio  <= w_prio_nxt;
    end
  end

  // Read data is captured at the grant edge and returned for one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
    end else begin
      r_m0_rvalid <= m0_gnt && (m0_we == 4'd0);
      r_m1_rvalid <= m1_gnt && (m1_we == 4'd0);
      if (m0_gnt && (m0_we == 4'd0)) r_m0_rdata <= w_rd_src;
      if (m1_gnt && (m1_we == 4'd0)) r_m1_rdata <= w_rd_src;
    end
  end

  assign m0_rvalid = r_m0_rvalid;
  assign m1_rvalid = r_m1_rvalid;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// tb_dmem_arbiter : directed and randomized checks of dmem_arbiter against a
//                   cycle-level ownership model.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

  localparam int MAXH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        breq  [2];
  logic [31:0] baddr [2];
  logic [3:0]  bwe   [2];
  logic [31:0] bwd   [2];

  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] daddr, dwdata, drdata, wdata, rdata;
  logic [3:0]  we;
  logic        ce_p, we_p;
  logic [1:0]  addr;

  int n_chk = 0;
  int n_err = 0;

  // model state
  int          mown, mhold, mptr;
  bit          mrv  [2];
  logic [31:0] mrd  [2];
  bit          macc [2];
  int          gq[$];
  logic [31:0] bnd [4] = '{32'h1FC, 32'h200, 32'h20C, 32'h210};

  always #5 clk = ~clk;

  function automatic logic [31:0] dmem_fn(logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'h5A5A0F0F);
  endfunction

  function automatic logic [31:0] preg_fn(logic [1:0] s);
    return 32'hC0DE0000 | {30'd0, s};
  endfunction

  function automatic bit is_p(logic [31:0] a);
    return (a >= 32'd512) && (a < 32'd528);
  endfunction

  assign drdata = dmem_fn(daddr);
  assign rdata  = preg_fn(addr);

  dmem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(breq[0]), .m0_addr(baddr[0]), .m0_we(bwe[0]), .m0_wdata(bwd[0]),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(breq[1]), .m1_addr(baddr[1]), .m1_we(bwe[1]), .m1_wdata(bwd[1]),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .daddr(daddr), .dwdata(dwdata), .we(we), .drdata(drdata),
    .ce_p(ce_p), .we_p(we_p), .addr(addr), .wdata(wdata), .rdata(rdata)
  );

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    mown = -1; mhold = 0; mptr = 0;
    for (int m = 0; m < 2; m++) begin
      mrv[m] = 0; mrd[m] = '0; macc[m] = 0;
    end
  endtask

  task automatic set_req(int m, logic r, logic [31:0] a, logic [3:0] w, logic [31:0] d);
    breq[m] = r; baddr[m] = a; bwe[m] = w; bwd[m] = d;
  endtask

  // One cycle: compare outputs against the model, advance the model over the edge
  task automatic step();
    bit          g [2];
    logic [31:0] a, e_da, e_dw, e_wd;
    logic [3:0]  e_we;
    logic        e_ce, e_wep;
    logic [1:0]  e_pa;
    int          o;
    #1;
    g[0] = 0; g[1] = 0;
    e_da = '0; e_dw = '0; e_wd = '0; e_we = '0; e_ce = 0; e_wep = 0; e_pa = '0; a = '0;
    if (mown >= 0 && breq[mown]) begin
      g[mown] = 1;
      a = baddr[mown];
      if (is_p(a)) begin
        e_ce = 1; e_wep = |bwe[mown]; e_pa = a[3:2]; e_wd = bwd[mown];
      end else begin
        e_da = a; e_dw = bwd[mown]; e_we = bwe[mown];
      end
    end
    chk("m0_gnt", m0_gnt, g[0]);
    chk("m1_gnt", m1_gnt, g[1]);
    chk("daddr", daddr, e_da);
    chk("dwdata", dwdata, e_dw);
    chk("we", we, e_we);
    chk("ce_p", ce_p, e_ce);
    chk("we_p", we_p, e_wep);
    chk("paddr", addr, e_pa);
    chk("pwdata", wdata, e_wd);
    chk("m0_rvalid", m0_rvalid, mrv[0]);
    chk("m1_rvalid", m1_rvalid, mrv[1]);
    chk("m0_rdata", m0_rdata, mrd[0]);
    chk("m1_rdata", m1_rdata, mrd[1]);
    mrv[0] = 0; mrv[1] = 0;
    if (mown < 0) begin
      if (breq[0] && breq[1]) mown = mptr;
      else if (breq[0])       mown = 0;
      else if (breq[1])       mown = 1;
    end else begin
      o = 1 - mown;
      if (g[mown]) begin
        mhold = (mhold + 1 > MAXH) ? MAXH : mhold + 1;
        mptr  = o;
        gq.push_back(mown);
        if (bwe[mown] == 4'd0) begin
          mrv[mown] = 1;
          mrd[mown] = is_p(a) ? preg_fn(a[3:2]) : dmem_fn(a);
        end
      end
      if (breq[o] && (!breq[mown] || mhold == MAXH)) begin
        mown = o; mhold = 0;
      end else if (!breq[mown] && !breq[o]) begin
        mown = -1; mhold = 0;
      end
    end
    macc[0] = g[0]; macc[1] = g[1];
    @(negedge clk);
  endtask

  task automatic wait_acc(int m);
    int n = 0;
    do begin
      step();
      n++;
    end while (!macc[m] && n < 20);
    chk("acc_timeout", macc[m], 1);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom % 6)
      0:       return 32'h200 + 32'(($urandom % 4) * 4);
      1:       return bnd[$urandom % 4];
      2:       return 32'hFFFF_FFFC;
      default: return 32'(($urandom % 256) * 4);
    endcase
  endfunction

  initial begin
    model_reset();
    reset_n = 1'b0;
    set_req(0, 1, 32'h100, 4'h0, 32'h0);
    set_req(1, 1, 32'h204, 4'h0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ctl", {26'd0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ce_p, we_p}, 32'd0);
    chk("rst_bus", daddr | dwdata | wdata | m0_rdata | m1_rdata, 32'd0);
    chk("rst_sel", {26'd0, we, addr}, 32'd0);

    // continuous contention: m0 x4, m1 x4, m0 x4
    @(negedge clk);
    reset_n = 1'b1;
    gq.delete();
    repeat (13) step();
    chk("rr_cnt", (gq.size() >= 12), 1);
    if (gq.size() >= 12)
      for (int i = 0; i < 12; i++) chk("rr_seq", gq[i], (i / 4) % 2);

    // single read from 0x100
    breq[0] = 0; breq[1] = 0;
    repeat (3) step();
    set_req(0, 1, 32'h100, 4'h0, 32'h0);
    wait_acc(0);
    breq[0] = 0;
    step();
    chk("rd_data", m0_rdata, 32'hDEADBEEF);
    step();

    // peripheral write, then read just past the window
    set_req(1, 1, 32'h204, 4'hF, 32'h55);
    wait_acc(1);
    set_req(1, 1, 32'h210, 4'h0, 32'h0);
    wait_acc(1);
    breq[1] = 0;
    repeat (3) step();

    // early release by m0, then next contention favours m0
    set_req(0, 1, 32'h108, 4'h0, 32'h0);
    set_req(1, 1, 32'h20C, 4'h3, 32'h1234);
    gq.delete();
    wait_acc(0);
    wait_acc(0);
    breq[0] = 0;
    wait_acc(1);
    breq[1] = 0;
    chk("er_cnt", gq.size(), 3);
    if (gq.size() == 3) chk("er_last", gq[2], 1);
    repeat (2) step();
    breq[0] = 1; breq[1] = 1;
    gq.delete();
    wait_acc(0);
    chk("er_first", (gq.size() == 1), 1);
    breq[0] = 0; breq[1] = 0;
    repeat (2) step();

    // randomized traffic, masters hold requests until accepted
    for (int c = 0; c < 3000; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!breq[m] || macc[m]) begin
          if ($urandom % 4 != 0)
            set_req(m, 1, rand_addr(), ($urandom % 2) ? 4'h0 : 4'($urandom_range(1, 15)), $urandom);
          else
            breq[m] = 0;
        end
      end
      step();
    end

    // asynchronous reset inside a read grant cycle
    breq[0] = 0; breq[1] = 0;
    repeat (3) step();
    set_req(0, 1, 32'h300, 4'hF, 32'hA5);
    wait_acc(0);
    breq[0] = 0;
    repeat (2) step();
    set_req(0, 1, 32'h100, 4'h0, 32'h0);
    step();
    #1;
    chk("mr_gnt", m0_gnt, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mr_gnt_rst", m0_gnt, 0);
    chk("mr_rv_rst", m0_rvalid, 0);
    model_reset();
    @(posedge clk);
    #1;
    chk("mr_rv_edge", m0_rvalid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    breq[1] = 1;
    gq.delete();
    wait_acc(0);
    chk("mr_prio", (gq.size() == 1), 1);
    breq[0] = 0; breq[1] = 0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
